// File: rtl/csr_pkg.sv
// Shared constants for the machine/supervisor CSR register file:
// CSR addresses, WARL write masks, privilege encodings and merge helpers.
package csr_pkg;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_SIE      = 12'h104;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_STVAL    = 12'h143;
  localparam logic [11:0] CSR_SIP      = 12'h144;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;
  localparam logic [11:0] CSR_MIDELEG  = 12'h303;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID= 12'hF11;
  localparam logic [11:0] CSR_MARCHID  = 12'hF12;
  localparam logic [11:0] CSR_MIMPID   = 12'hF13;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [31:0] MISA_DEFAULT  = 32'h4014_1105;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_19AA;
  localparam logic [31:0] SSTATUS_MASK  = 32'h0000_0122;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0AAA;
  localparam logic [31:0] MIP_WMASK     = 32'h0000_0222;
  localparam logic [31:0] MIDELEG_WMASK = 32'h0000_0222;
  localparam logic [31:0] MEDELEG_WMASK = 32'h0000_B3FF;
  localparam logic [31:0] S_INT_MASK    = 32'h0000_0222;

  function automatic logic [31:0] merge_bits(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // MPP has no hypervisor mode, so the reserved encoding 2'b10 collapses to U.
  function automatic logic [31:0] mstatus_legalize(input logic [31:0] v);
    logic [31:0] r;
    r = v & MSTATUS_WMASK;
    if (r[12:11] == 2'b10) begin
      r[12:11] = 2'b00;
    end else begin
      r[12:11] = r[12:11];
    end
    return r;
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// CSR access bus: trap-controller write port and write-back Zicsr read/write port.
interface csr_regfile_if;
  logic        trap_we_i;
  logic [11:0] trap_waddr_i;
  logic [31:0] trap_wdata_i;
  logic        inst_we_i;
  logic [11:0] inst_waddr_i;
  logic [31:0] inst_wdata_i;
  logic [11:0] inst_raddr_i;
  logic        inst_wr_check_i;
  logic [31:0] inst_rdata_o;
  logic        inst_illegal_o;

  modport master (
    output trap_we_i, trap_waddr_i, trap_wdata_i,
    output inst_we_i, inst_waddr_i, inst_wdata_i,
    output inst_raddr_i, inst_wr_check_i,
    input  inst_rdata_o, inst_illegal_o
  );

  modport slave (
    input  trap_we_i, trap_waddr_i, trap_wdata_i,
    input  inst_we_i, inst_waddr_i, inst_wdata_i,
    input  inst_raddr_i, inst_wr_check_i,
    output inst_rdata_o, inst_illegal_o
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit performance counter; a write to either half wins over the increment
// for the whole counter in that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (we_lo_i || we_hi_i) begin
      lo_d = we_lo_i ? wdata_i : lo_q;
      hi_d = we_hi_i ? wdata_i : hi_q;
    end else if (inc_i) begin
      {hi_d, lo_d} = {hi_q, lo_q} + 64'd1;
    end else begin
      lo_d = lo_q;
      hi_d = hi_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lo_q <= 32'h0000_0000;
      hi_q <= 32'h0000_0000;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_regfile.sv
// Machine/supervisor CSR register file: trap CSRs, hart privilege and the
// cycle/instret counters, with one read port and two prioritised write ports.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = MISA_DEFAULT,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  csr_regfile_if.slave      bus,
  input  logic              privilege_we_i,
  input  logic [1:0]        privilege_i,
  output logic [1:0]        privilege_o,
  input  logic              timer_irq_i,
  input  logic              retire_i,
  output logic [31:0]       csr_mstatus_o,
  output logic [31:0]       csr_mtvec_o,
  output logic [31:0]       csr_mepc_o,
  output logic [31:0]       csr_mcause_o,
  output logic [31:0]       csr_mtval_o,
  output logic [31:0]       csr_mie_o,
  output logic [31:0]       csr_mip_o,
  output logic [31:0]       csr_medeleg_o,
  output logic [31:0]       csr_mideleg_o,
  output logic [31:0]       csr_stvec_o,
  output logic [31:0]       csr_sepc_o,
  output logic [31:0]       csr_scause_o,
  output logic [31:0]       csr_stval_o,
  output logic [31:0]       csr_sstatus_o,
  output logic [31:0]       csr_sie_o,
  output logic [31:0]       csr_sip_o,
  output logic [31:0]       csr_satp_o
);

  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mip_q, mip_d;
  logic [31:0] medeleg_q, medeleg_d, mideleg_q, mideleg_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] stvec_q, stvec_d, sscratch_q, sscratch_d, sepc_q, sepc_d;
  logic [31:0] scause_q, scause_d, stval_q, stval_d, satp_q, satp_d;
  logic [1:0]  priv_q, priv_d;
  logic        mtip_q, mtip_d;

  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        cyc_we_lo, cyc_we_hi, ins_we_lo, ins_we_hi;
  logic [63:0] mcycle, minstret;
  logic [31:0] mip_view, s_deleg;
  logic [31:0] rd_val;
  logic        rd_impl;

  // The trap port owns the write path whenever it is active.
  assign wr_en   = bus.trap_we_i | bus.inst_we_i;
  assign wr_addr = bus.trap_we_i ? bus.trap_waddr_i : bus.inst_waddr_i;
  assign wr_data = bus.trap_we_i ? bus.trap_wdata_i : bus.inst_wdata_i;

  assign s_deleg  = mideleg_q & S_INT_MASK;
  assign mip_view = mip_q | {24'h00_0000, mtip_q, 7'h00};

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mip_d      = mip_q;
    medeleg_d  = medeleg_q;
    mideleg_d  = mideleg_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    stvec_d    = stvec_q;
    sscratch_d = sscratch_q;
    sepc_d     = sepc_q;
    scause_d   = scause_q;
    stval_d    = stval_q;
    satp_d     = satp_q;
    cyc_we_lo  = 1'b0;
    cyc_we_hi  = 1'b0;
    ins_we_lo  = 1'b0;
    ins_we_hi  = 1'b0;
    priv_d     = privilege_we_i ? privilege_i : priv_q;
    mtip_d     = timer_irq_i;
    if (wr_en) begin
      case (wr_addr)
        CSR_SSTATUS:   mstatus_d  = merge_bits(mstatus_q, wr_data, SSTATUS_MASK);
        CSR_SIE:       mie_d      = merge_bits(mie_q, wr_data, s_deleg);
        CSR_SIP:       mip_d      = merge_bits(mip_q, wr_data, s_deleg);
        CSR_STVEC:     stvec_d    = wr_data & ~32'h0000_0002;
        CSR_SSCRATCH:  sscratch_d = wr_data;
        CSR_SEPC:      sepc_d     = wr_data & ~32'h0000_0001;
        CSR_SCAUSE:    scause_d   = wr_data;
        CSR_STVAL:     stval_d    = wr_data;
        CSR_SATP:      satp_d     = wr_data;
        CSR_MSTATUS:   mstatus_d  = mstatus_legalize(wr_data);
        CSR_MEDELEG:   medeleg_d  = wr_data & MEDELEG_WMASK;
        CSR_MIDELEG:   mideleg_d  = wr_data & MIDELEG_WMASK;
        CSR_MIE:       mie_d      = wr_data & MIE_WMASK;
        CSR_MTVEC:     mtvec_d    = wr_data & ~32'h0000_0002;
        CSR_MSCRATCH:  mscratch_d = wr_data;
        CSR_MEPC:      mepc_d     = wr_data & ~32'h0000_0001;
        CSR_MCAUSE:    mcause_d   = wr_data;
        CSR_MTVAL:     mtval_d    = wr_data;
        CSR_MIP:       mip_d      = wr_data & MIP_WMASK;
        CSR_MCYCLE:    cyc_we_lo  = 1'b1;
        CSR_MCYCLEH:   cyc_we_hi  = 1'b1;
        CSR_MINSTRET:  ins_we_lo  = 1'b1;
        CSR_MINSTRETH: ins_we_hi  = 1'b1;
        default:       mstatus_d  = mstatus_q;
      endcase
    end else begin
      mstatus_d = mstatus_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_q  <= 32'h0000_0000;
      mie_q      <= 32'h0000_0000;
      mip_q      <= 32'h0000_0000;
      medeleg_q  <= 32'h0000_0000;
      mideleg_q  <= 32'h0000_0000;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0000_0000;
      mepc_q     <= 32'h0000_0000;
      mcause_q   <= 32'h0000_0000;
      mtval_q    <= 32'h0000_0000;
      stvec_q    <= 32'h0000_0000;
      sscratch_q <= 32'h0000_0000;
      sepc_q     <= 32'h0000_0000;
      scause_q   <= 32'h0000_0000;
      stval_q    <= 32'h0000_0000;
      satp_q     <= 32'h0000_0000;
      priv_q     <= PRIV_M;
      mtip_q     <= 1'b0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      medeleg_q  <= medeleg_d;
      mideleg_q  <= mideleg_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      stvec_q    <= stvec_d;
      sscratch_q <= sscratch_d;
      sepc_q     <= sepc_d;
      scause_q   <= scause_d;
      stval_q    <= stval_d;
      satp_q     <= satp_d;
      priv_q     <= priv_d;
      mtip_q     <= mtip_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .we_lo_i (cyc_we_lo),
    .we_hi_i (cyc_we_hi),
    .wdata_i (wr_data),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (retire_i),
    .we_lo_i (ins_we_lo),
    .we_hi_i (ins_we_hi),
    .wdata_i (wr_data),
    .count_o (minstret)
  );

  always_comb begin
    rd_val  = 32'h0000_0000;
    rd_impl = 1'b1;
    case (bus.inst_raddr_i)
      CSR_SSTATUS:   rd_val = mstatus_q & SSTATUS_MASK;
      CSR_SIE:       rd_val = mie_q & s_deleg;
      CSR_SIP:       rd_val = mip_view & s_deleg;
      CSR_STVEC:     rd_val = stvec_q;
      CSR_SSCRATCH:  rd_val = sscratch_q;
      CSR_SEPC:      rd_val = sepc_q;
      CSR_SCAUSE:    rd_val = scause_q;
      CSR_STVAL:     rd_val = stval_q;
      CSR_SATP:      rd_val = satp_q;
      CSR_MSTATUS:   rd_val = mstatus_q;
      CSR_MISA:      rd_val = MISA_VALUE;
      CSR_MEDELEG:   rd_val = medeleg_q;
      CSR_MIDELEG:   rd_val = mideleg_q;
      CSR_MIE:       rd_val = mie_q;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MTVAL:     rd_val = mtval_q;
      CSR_MIP:       rd_val = mip_view;
      CSR_MCYCLE,    CSR_CYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   rd_val = mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  rd_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd_val = 32'h0000_0000;
      CSR_MHARTID:   rd_val = HART_ID;
      default:       rd_impl = 1'b0;
    endcase
  end

  // Top two address bits mark read-only space; bits [9:8] the lowest privilege allowed.
  assign bus.inst_illegal_o = ~rd_impl
                            | (bus.inst_raddr_i[9:8] > priv_q)
                            | ((bus.inst_raddr_i[11:10] == 2'b11) & bus.inst_wr_check_i);
  assign bus.inst_rdata_o   = bus.inst_illegal_o ? 32'h0000_0000 : rd_val;

  assign privilege_o   = priv_q;
  assign csr_mstatus_o = mstatus_q;
  assign csr_mtvec_o   = mtvec_q;
  assign csr_mepc_o    = mepc_q;
  assign csr_mcause_o  = mcause_q;
  assign csr_mtval_o   = mtval_q;
  assign csr_mie_o     = mie_q;
  assign csr_mip_o     = mip_view;
  assign csr_medeleg_o = medeleg_q;
  assign csr_mideleg_o = mideleg_q;
  assign csr_stvec_o   = stvec_q;
  assign csr_sepc_o    = sepc_q;
  assign csr_scause_o  = scause_q;
  assign csr_stval_o   = stval_q;
  assign csr_sstatus_o = mstatus_q & SSTATUS_MASK;
  assign csr_sie_o     = mie_q & s_deleg;
  assign csr_sip_o     = mip_view & s_deleg;
  assign csr_satp_o    = satp_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        privilege_we_i;
  logic [1:0]  privilege_i;
  logic [1:0]  privilege_o;
  logic        timer_irq_i;
  logic        retire_i;
  logic [31:0] csr_mstatus_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mtval_o;
  logic [31:0] csr_mie_o, csr_mip_o, csr_medeleg_o, csr_mideleg_o, csr_stvec_o;
  logic [31:0] csr_sepc_o, csr_scause_o, csr_stval_o, csr_sstatus_o, csr_sie_o;
  logic [31:0] csr_sip_o, csr_satp_o;

  int n_tests = 0;
  int n_fail  = 0;

  csr_regfile_if bus();

  csr_regfile #(
    .MTVEC_RESET (32'h0000_0000),
    .MISA_VALUE  (32'h4014_1105),
    .HART_ID     (32'd0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .privilege_we_i (privilege_we_i),
    .privilege_i    (privilege_i),
    .privilege_o    (privilege_o),
    .timer_irq_i    (timer_irq_i),
    .retire_i       (retire_i),
    .csr_mstatus_o  (csr_mstatus_o),
    .csr_mtvec_o    (csr_mtvec_o),
    .csr_mepc_o     (csr_mepc_o),
    .csr_mcause_o   (csr_mcause_o),
    .csr_mtval_o    (csr_mtval_o),
    .csr_mie_o      (csr_mie_o),
    .csr_mip_o      (csr_mip_o),
    .csr_medeleg_o  (csr_medeleg_o),
    .csr_mideleg_o  (csr_mideleg_o),
    .csr_stvec_o    (csr_stvec_o),
    .csr_sepc_o     (csr_sepc_o),
    .csr_scause_o   (csr_scause_o),
    .csr_stval_o    (csr_stval_o),
    .csr_sstatus_o  (csr_sstatus_o),
    .csr_sie_o      (csr_sie_o),
    .csr_sip_o      (csr_sip_o),
    .csr_satp_o     (csr_satp_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic trap_wr(input logic [11:0] a, input logic [31:0] d);
    bus.trap_we_i = 1'b1; bus.trap_waddr_i = a; bus.trap_wdata_i = d;
    step();
    bus.trap_we_i = 1'b0;
  endtask

  task automatic inst_wr(input logic [11:0] a, input logic [31:0] d);
    bus.inst_we_i = 1'b1; bus.inst_waddr_i = a; bus.inst_wdata_i = d;
    step();
    bus.inst_we_i = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic wrc,
                    output logic [31:0] d, output logic ill);
    bus.inst_raddr_i = a; bus.inst_wr_check_i = wrc;
    #1;
    d = bus.inst_rdata_o; ill = bus.inst_illegal_o;
  endtask

  task automatic set_priv(input logic [1:0] p);
    privilege_we_i = 1'b1; privilege_i = p;
    step();
    privilege_we_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic ill; logic [31:0] others;
    rst = 1'b0;
    repeat (3) step();
    others = csr_mstatus_o | csr_mepc_o | csr_mcause_o | csr_mtval_o | csr_mie_o |
             csr_mip_o | csr_medeleg_o | csr_mideleg_o | csr_stvec_o | csr_sepc_o |
             csr_scause_o | csr_stval_o | csr_sstatus_o | csr_sie_o | csr_sip_o | csr_satp_o;
    n_tests++; if (privilege_o !== 2'b11) begin n_fail++; $display("FAIL reset_priv: got %b want 11", privilege_o); end
    n_tests++; if (csr_mtvec_o !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_mtvec: got %h want 00000000", csr_mtvec_o); end
    n_tests++; if (others !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_csrs: or-of-all got %h want 00000000", others); end
    rst = 1'b1;
    step();
    rd(12'hB00, 1'b0, d, ill);
    n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL reset_mcycle: got %h want 00000001", d); end
  endtask

  task automatic test_trap_write();
    logic [31:0] d; logic ill;
    bus.trap_we_i = 1'b1; bus.trap_waddr_i = 12'h341; bus.trap_wdata_i = 32'h8000_0103;
    bus.inst_we_i = 1'b1; bus.inst_waddr_i = 12'h341; bus.inst_wdata_i = 32'h1234_5678;
    step();
    bus.inst_we_i = 1'b0;
    bus.trap_waddr_i = 12'h342; bus.trap_wdata_i = 32'h8000_0007;
    step();
    bus.trap_we_i = 1'b0;
    n_tests++; if (csr_mepc_o !== 32'h8000_0102) begin n_fail++; $display("FAIL trap_mepc: got %h want 80000102", csr_mepc_o); end
    n_tests++; if (csr_mcause_o !== 32'h8000_0007) begin n_fail++; $display("FAIL trap_mcause: got %h want 80000007", csr_mcause_o); end
    rd(12'h341, 1'b0, d, ill);
    n_tests++; if (d !== 32'h8000_0102) begin n_fail++; $display("FAIL trap_mepc_read: got %h want 80000102", d); end
  endtask

  task automatic test_alias_masks();
    inst_wr(12'h303, 32'h0000_0222);
    inst_wr(12'h104, 32'hFFFF_FFFF);
    n_tests++; if (csr_mie_o !== 32'h0000_0222) begin n_fail++; $display("FAIL sie_merge: mie got %h want 00000222", csr_mie_o); end
    n_tests++; if (csr_sie_o !== 32'h0000_0222) begin n_fail++; $display("FAIL sie_view: got %h want 00000222", csr_sie_o); end
    inst_wr(12'h100, 32'hFFFF_FFFF);
    n_tests++; if (csr_mstatus_o !== 32'h0000_0122) begin n_fail++; $display("FAIL sstatus_merge: mstatus got %h want 00000122", csr_mstatus_o); end
    inst_wr(12'h300, 32'h0000_1000);
    n_tests++; if (csr_mstatus_o !== 32'h0000_0000) begin n_fail++; $display("FAIL mpp_warl: got %h want 00000000", csr_mstatus_o); end
    inst_wr(12'h300, 32'hFFFF_FFFF);
    n_tests++; if (csr_mstatus_o !== 32'h0000_19AA) begin n_fail++; $display("FAIL mstatus_mask: got %h want 000019aa", csr_mstatus_o); end
    inst_wr(12'h305, 32'hFFFF_FFFF);
    n_tests++; if (csr_mtvec_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL mtvec_bit1: got %h want fffffffd", csr_mtvec_o); end
    inst_wr(12'h302, 32'hFFFF_FFFF);
    n_tests++; if (csr_medeleg_o !== 32'h0000_B3FF) begin n_fail++; $display("FAIL medeleg_mask: got %h want 0000b3ff", csr_medeleg_o); end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] d; logic ill;
    inst_wr(12'hB80, 32'h0000_0010);
    inst_wr(12'hB00, 32'hFFFF_FFFE);
    step();
    step();
    rd(12'hB00, 1'b0, d, ill);
    n_tests++; if (d !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_lo: got %h want 00000000", d); end
    rd(12'hB80, 1'b0, d, ill);
    n_tests++; if (d !== 32'h0000_0011) begin n_fail++; $display("FAIL wrap_hi: got %h want 00000011", d); end
    inst_wr(12'hB00, 32'hFFFF_FFFE);
    step();
    inst_wr(12'hB00, 32'h0000_0005);
    rd(12'hB00, 1'b0, d, ill);
    n_tests++; if (d !== 32'h0000_0005) begin n_fail++; $display("FAIL wrap_write_lo: got %h want 00000005", d); end
    rd(12'hB80, 1'b0, d, ill);
    n_tests++; if (d !== 32'h0000_0011) begin n_fail++; $display("FAIL wrap_write_hi: got %h want 00000011", d); end
    retire_i = 1'b1;
    repeat (3) step();
    retire_i = 1'b0;
    rd(12'hC02, 1'b0, d, ill);
    n_tests++; if (d !== 32'h0000_0003) begin n_fail++; $display("FAIL instret: got %h want 00000003", d); end
  endtask

  task automatic test_privilege();
    logic [31:0] d; logic ill;
    set_priv(2'b00);
    n_tests++; if (privilege_o !== 2'b00) begin n_fail++; $display("FAIL priv_load: got %b want 00", privilege_o); end
    rd(12'h300, 1'b0, d, ill);
    n_tests++; if (ill !== 1'b1) begin n_fail++; $display("FAIL u_mstatus_ill: got %b want 1", ill); end
    n_tests++; if (d !== 32'h0000_0000) begin n_fail++; $display("FAIL u_mstatus_data: got %h want 00000000", d); end
    rd(12'h100, 1'b0, d, ill);
    n_tests++; if (ill !== 1'b1) begin n_fail++; $display("FAIL u_sstatus_ill: got %b want 1", ill); end
    rd(12'hC00, 1'b0, d, ill);
    n_tests++; if (ill !== 1'b0) begin n_fail++; $display("FAIL u_cycle_legal: got %b want 0", ill); end
    set_priv(2'b11);
    rd(12'hC00, 1'b1, d, ill);
    n_tests++; if (ill !== 1'b1) begin n_fail++; $display("FAIL m_cycle_write_ill: got %b want 1", ill); end
    rd(12'h7C0, 1'b0, d, ill);
    n_tests++; if (ill !== 1'b1) begin n_fail++; $display("FAIL unimpl_ill: got %b want 1", ill); end
    rd(12'h301, 1'b0, d, ill);
    n_tests++; if (d !== 32'h4014_1105) begin n_fail++; $display("FAIL misa: got %h want 40141105", d); end
    rd(12'hF14, 1'b0, d, ill);
    n_tests++; if (ill !== 1'b0) begin n_fail++; $display("FAIL hartid_legal: got %b want 0", ill); end
    bus.inst_wr_check_i = 1'b0;
  endtask

  task automatic test_timer();
    timer_irq_i = 1'b1;
    step();
    n_tests++; if (csr_mip_o[7] !== 1'b1) begin n_fail++; $display("FAIL mtip_set: got %b want 1", csr_mip_o[7]); end
    trap_wr(12'h344, 32'h0000_0002);
    n_tests++; if (csr_mip_o !== 32'h0000_0082) begin n_fail++; $display("FAIL mtip_ro: got %h want 00000082", csr_mip_o); end
    timer_irq_i = 1'b0;
    step();
    n_tests++; if (csr_mip_o !== 32'h0000_0002) begin n_fail++; $display("FAIL mtip_clear: got %h want 00000002", csr_mip_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic ill;
    bus.trap_we_i = 1'b1;
    bus.trap_waddr_i = 12'h341; bus.trap_wdata_i = 32'h2000_0004; step();
    bus.trap_waddr_i = 12'h342; bus.trap_wdata_i = 32'h0000_000B; step();
    bus.trap_waddr_i = 12'h343; bus.trap_wdata_i = 32'hDEAD_BEEF; step();
    bus.trap_waddr_i = 12'h300; bus.trap_wdata_i = 32'h0000_1880; step();
    bus.trap_waddr_i = 12'h344; bus.trap_wdata_i = 32'h0000_0020; step();
    bus.trap_we_i = 1'b0;
    n_tests++; if (csr_mepc_o !== 32'h2000_0004) begin n_fail++; $display("FAIL b2b_mepc: got %h want 20000004", csr_mepc_o); end
    n_tests++; if (csr_mcause_o !== 32'h0000_000B) begin n_fail++; $display("FAIL b2b_mcause: got %h want 0000000b", csr_mcause_o); end
    n_tests++; if (csr_mtval_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_mtval: got %h want deadbeef", csr_mtval_o); end
    n_tests++; if (csr_mstatus_o !== 32'h0000_1880) begin n_fail++; $display("FAIL b2b_mstatus: got %h want 00001880", csr_mstatus_o); end
    n_tests++; if (csr_mip_o !== 32'h0000_0020) begin n_fail++; $display("FAIL b2b_mip: got %h want 00000020", csr_mip_o); end
    // Reset lands in the middle of a second trap sequence.
    set_priv(2'b01);
    trap_wr(12'h141, 32'h0000_0100);
    rst = 1'b0;
    bus.trap_we_i = 1'b1;
    bus.trap_waddr_i = 12'h142; bus.trap_wdata_i = 32'h0000_0005; step();
    bus.trap_waddr_i = 12'h143; bus.trap_wdata_i = 32'h0000_0077; step();
    bus.trap_we_i = 1'b0;
    rst = 1'b1;
    n_tests++; if (csr_scause_o !== 32'h0000_0000) begin n_fail++; $display("FAIL rst_scause: got %h want 00000000", csr_scause_o); end
    n_tests++; if (csr_stval_o !== 32'h0000_0000) begin n_fail++; $display("FAIL rst_stval: got %h want 00000000", csr_stval_o); end
    n_tests++; if (privilege_o !== 2'b11) begin n_fail++; $display("FAIL rst_priv: got %b want 11", privilege_o); end
    rd(12'hB00, 1'b0, d, ill);
    n_tests++; if (d !== 32'h0000_0000) begin n_fail++; $display("FAIL rst_mcycle: got %h want 00000000", d); end
  endtask

  initial begin
    rst = 1'b0;
    privilege_we_i = 1'b0; privilege_i = 2'b00;
    timer_irq_i = 1'b0; retire_i = 1'b0;
    bus.trap_we_i = 1'b0; bus.trap_waddr_i = 12'h000; bus.trap_wdata_i = 32'h0000_0000;
    bus.inst_we_i = 1'b0; bus.inst_waddr_i = 12'h000; bus.inst_wdata_i = 32'h0000_0000;
    bus.inst_raddr_i = 12'h000; bus.inst_wr_check_i = 1'b0;
    test_reset();
    test_trap_write();
    test_alias_masks();
    test_counter_wrap();
    test_privilege();
    test_timer();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine/supervisor CSR register file: the responder for the trap controller's serial CSR write port and for the write-back stage's Zicsr instruction accesses. Holds every trap-related CSR, the hart privilege level and the 64-bit cycle/instret counters. Drives the registered CSR value buses that the trap controller reads. Sits beside the write-back stage; one read port and two write ports.

## Interface
- `MTVEC_RESET`, 32'h0000_0000, reset value of mtvec.
- `MISA_VALUE`, 32'h4014_1105, constant returned for misa (RV32 IMACSU).
- `HART_ID`, 0, value of mhartid.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-low reset.
- `trap_we_i` / `trap_waddr_i` / `trap_wdata_i` in 1/12/32: trap-controller write port.
- `inst_we_i` / `inst_waddr_i` / `inst_wdata_i` in 1/12/32: write-back CSR instruction write port (final value, already combined for CSRRS/CSRRC).
- `inst_raddr_i` in 12: instruction read address.
- `inst_rdata_o` out 32: combinational read data.
- `inst_illegal_o` out 1: combinational; the access at `inst_raddr_i` is illegal.
- `inst_wr_check_i` in 1: qualifies the illegal check as a write.
- `privilege_we_i` / `privilege_i` in 1/2: privilege update from the trap controller.
- `privilege_o` out 2: current privilege.
- `timer_irq_i` in 1: mtime ≥ mtimecmp.
- `retire_i` in 1: one instruction retired this cycle.
- `csr_mstatus_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mtval_o, csr_mie_o, csr_mip_o, csr_medeleg_o, csr_mideleg_o, csr_stvec_o, csr_sepc_o, csr_scause_o, csr_stval_o, csr_sstatus_o, csr_sie_o, csr_sip_o, csr_satp_o` out 32 each: registered views.

## Operation
- Physical storage: mstatus, mie, mip (SSIP/STIP/SEIP only), medeleg, mideleg, mtvec, mscratch, mepc, mcause, mtval, stvec, sscratch, sepc, scause, stval, satp, privilege, mcycle[63:0], minstret[63:0].
- Aliased views:
  - sstatus = mstatus & 0x0000_0122.
  - sie = mie & mideleg & 0x222.
  - sip = mip & mideleg & 0x222.
  - sstatus/sie/sip writes merge into mstatus/mie/mip under the same masks.
- mip bit 7 (MTIP) = `timer_irq_i`, read-only. Writes to it are ignored, including the trap controller's pending-set write.
- Write masks (WARL):
  - mstatus 0x0000_19AA; an MPP write of 2'b10 stores 2'b00.
  - mie 0xAAA; mip 0x222; mideleg 0x222; medeleg 0xB3FF.
  - mtvec/stvec: bit 1 forced 0.
  - mepc/sepc: bit 0 forced 0.
  - Others: all 32 bits.
- Addresses are standard:
  - 0x1xx/0x3xx trap CSRs, 0x180 satp.
  - 0xB00/0xB80/0xB02/0xB82 counters; 0xC00/0xC80/0xC02/0xC82 read-only shadows.
  - 0xF11–0xF14 read-only IDs (vendor/arch/imp = 0, hartid = `HART_ID`).
- Illegal: unimplemented address; addr[9:8] > privilege; or addr[11:10] == 2'b11 with `inst_wr_check_i`. Illegal reads return 0.
- Write priority:
  - The trap port wins when both ports write in the same cycle; the instruction write is dropped.
  - An instruction write flagged illegal by the pipeline never reaches this block. A write to an unimplemented or read-only address on either port is ignored.
- Counters:
  - mcycle increments by 1 every cycle out of reset. minstret increments when `retire_i` is high.
  - A write to either 32-bit half replaces that half. The increment is suppressed in that cycle, with no carry into or out of the written half.
  - Low-half wrap 0xFFFF_FFFF → 0 carries into the high half; 64-bit wrap goes to 0.
- Privilege: loads `privilege_i` when `privilege_we_i` is high; a concurrent CSR write does not affect it.

## Timing
- Reset (rst low at clk edge):
  - All CSRs 0, except mtvec = `MTVEC_RESET` and privilege = 2'b11.
  - Counters 0. All `csr_*_o` reflect these values the cycle after reset.
- Writes take effect at the clk edge. No read bypass: new value visible on `inst_rdata_o` and `csr_*_o` the following cycle.
- Serial trap sequence (epc, cause, tval, status, pending on consecutive cycles) is accepted back-to-back, one write per cycle.
- Reset asserted mid-sequence discards any remaining writes. Counters restart from 0.

## Structure
- `csr_pkg`: 12-bit address constants, write masks, `MISA_VALUE` default, privilege encodings (U=00, S=01, M=11).
- One sub-module, `csr_counter64`: 64-bit counter with increment enable, per-half write enable/data, and the write-beats-increment rule. Instantiated twice.

## Test plan
- Reset → `privilege_o`=2'b11, `csr_mtvec_o`=`MTVEC_RESET`, all other CSRs 0. mcycle reads 1 on the first cycle after reset.
- Trap port writes 0x341←0x8000_0103 then 0x342←0x8000_0007 → mepc reads 0x8000_0102, mcause 0x8000_0007. Same-cycle instruction write to 0x341 is lost.
- Set mideleg=0x222, write sie←0xFFFF_FFFF → mie=0x222. Write sstatus←0xFFFF_FFFF with mstatus=0 → mstatus=0x122.
- mcycle low=0xFFFF_FFFE: two cycles → low 0, high +1. A write mcycle←5 in the wrap cycle → low reads 5 next cycle, high unchanged.
- Privilege U: read 0x300 → illegal, data 0. Read 0xC00 → legal. Privilege M write to 0xC00 with `inst_wr_check_i` → illegal.
- `timer_irq_i`=1 → mip bit 7 set the next cycle. Trap-port write to 0x344 with bit 7 = 0 → bit still 1.
